// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ producers.
// Optional burst grants are enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [ID_WIDTH-1:0] pick_c;
    logic                pick_vld_c;
    logic                release_c;

    // First valid requester after the previous grantee, wrapping modulo NUM_REQ
    always_comb begin
        pick_c     = '0;
        pick_vld_c = 1'b0;
        scan_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_WIDTH'((32'(last_grant_q) + k) % NUM_REQ);
            if (!pick_vld_c && req_valid[scan_idx]) begin
                pick_c     = scan_idx;
                pick_vld_c = 1'b1;
            end
        end
    end

    // Zero-latency write path; rst blocks any handshake in the same cycle
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == GRANT && !rst) begin
            req_ready[grant_id_q] = ~fifo_full;
            fifo_wr_en            = req_valid[grant_id_q] & ~fifo_full;
        end
    end

`ifdef FIFO_ARB_BURST_EN
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

    assign release_c = fifo_wr_en &&
                       (req_last[grant_id_q] || beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1));
`else
    logic unused_last;

    assign release_c   = fifo_wr_en;
    assign unused_last = ^req_last;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
`ifdef FIFO_ARB_BURST_EN
        beat_cnt_d   = beat_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld_c) begin
                    state_d    = GRANT;
                    grant_id_d = pick_c;
`ifdef FIFO_ARB_BURST_EN
                    beat_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
`ifdef FIFO_ARB_BURST_EN
                if (fifo_wr_en) begin
                    beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                end
`endif
                if (release_c) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            grant_id_q   <= '0;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt_q   <= beat_cnt_d;
`endif
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: fixed vector table, directed corner sequences and
// random traffic checked against a cycle model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int MB  = 8;
    localparam int CW  = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [IDW-1:0]  grant_id;
    logic            busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .grant_id(grant_id), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: owner < 0 means nobody holds the port
    int m_owner = -1;
    int m_last  = N - 1;
    int m_gid   = 0;
    int m_beats = 0;

    logic [N-1:0]   exp_ready, act_ready;
    logic           exp_wr, act_wr, exp_busy, act_busy;
    logic [IDW-1:0] exp_gid, act_gid;
    logic [DW-1:0]  exp_data, act_data, cur_gid_data;

    typedef struct {
        logic           r;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic           f;
        logic [N-1:0]   rdy;
        logic           wr;
        logic           bsy;
        logic [IDW-1:0] gid;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle, sample mid-cycle, then advance the model past the next edge
    task automatic apply(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic f);
        bit found;
        int c;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        @(negedge clk);
        act_ready    = req_ready;
        act_wr       = fifo_wr_en;
        act_busy     = busy;
        act_gid      = grant_id;
        act_data     = fifo_wr_data;
        cur_gid_data = req_data[int'(grant_id)*DW +: DW];

        exp_busy  = (m_owner >= 0);
        exp_gid   = IDW'(m_gid);
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_data  = '0;
        if (m_owner >= 0) exp_data = req_data[m_owner*DW +: DW];
        if (m_owner >= 0 && !r && !f) begin
            exp_ready[m_owner] = 1'b1;
            exp_wr             = v[m_owner];
        end

        if (r) begin
            m_owner = -1; m_last = N - 1; m_gid = 0; m_beats = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && v[c]) begin
                    found = 1'b1; m_owner = c; m_gid = c; m_beats = 0;
                end
            end
        end else if (exp_wr) begin
            m_beats++;
            if (!BURST || l[m_owner] || m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic model_check();
        check("ready", 64'(act_ready), 64'(exp_ready));
        check("wr_en", 64'(act_wr), 64'(exp_wr));
        check("busy", 64'(act_busy), 64'(exp_busy));
        check("grant_id", 64'(act_gid), 64'(exp_gid));
        if (exp_wr) check("wr_data", 64'(act_data), 64'(exp_data));
        if (fifo_full && act_wr) check("wr_while_full", 64'(act_wr), 64'(0));
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic f);
        apply(r, v, l, f);
        model_check();
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
    endtask

    initial begin
        bit seen2;
        int pattern;
        rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;

        //              r     v        l        f     rdy      wr    bsy   gid
        tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};
        tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2};
        tbl[6]  = '{1'b0, 4'b1011, 4'b1111, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2};
        tbl[9]  = '{1'b1, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0};
        tbl[10] = '{1'b0, 4'b0110, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 4'b0110, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        tbl[12] = '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};
        tbl[13] = '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1};

        apply(1'b1, '0, '0, 1'b0);
        apply(1'b1, '0, '0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].f);
            check($sformatf("tbl%0d_ready", i), 64'(act_ready), 64'(tbl[i].rdy));
            check($sformatf("tbl%0d_wr_en", i), 64'(act_wr), 64'(tbl[i].wr));
            check($sformatf("tbl%0d_busy", i), 64'(act_busy), 64'(tbl[i].bsy));
            check($sformatf("tbl%0d_gid", i), 64'(act_gid), 64'(tbl[i].gid));
            if (tbl[i].wr) check($sformatf("tbl%0d_data", i), 64'(act_data), 64'(cur_gid_data));
        end

        // all requesters valid, single-beat grants: one write every other cycle in order
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b1111, 4'b1111, 1'b0);
            check("rr_wr_en", 64'(act_wr), 64'(c % 2));
            if (c % 2 == 1) check("rr_gid", 64'(act_gid), 64'(((c - 1) / 2) % N));
        end

        // full for 5 cycles during a grant
        do_reset();
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b1111, 4'b0000, 1'b1);
            check("full_wr_en", 64'(act_wr), 64'(0));
            check("full_ready", 64'(act_ready), 64'(0));
            check("full_gid", 64'(act_gid), 64'(0));
        end
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        check("full_resume", 64'(act_wr), 64'(1));
        for (int c = 0; c < 10; c++) step(1'b0, 4'b0001, 4'b0000, 1'b0);

        // grantee drops valid for 3 cycles while others wait
        do_reset();
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 4'b1110, 4'b0000, 1'b0);
            check("drop_wr_en", 64'(act_wr), 64'(0));
            check("drop_busy", 64'(act_busy), 64'(1));
            check("drop_gid", 64'(act_gid), 64'(0));
        end
        step(1'b0, 4'b1111, 4'b1111, 1'b0);
        check("drop_resume", 64'(act_wr), 64'(1));
        check("drop_resume_gid", 64'(act_gid), 64'(0));

`ifdef FIFO_ARB_BURST_EN
        // requester 2 streams without last: capped at MB beats, then rotation to 1
        do_reset();
        step(1'b0, 4'b0100, 4'b0000, 1'b0);
        for (int b = 0; b < MB; b++) begin
            step(1'b0, 4'b0110, 4'b0000, 1'b0);
            check("burst_wr_en", 64'(act_wr), 64'(1));
            check("burst_gid", 64'(act_gid), 64'(2));
        end
        step(1'b0, 4'b0110, 4'b0000, 1'b0);
        check("burst_bubble", 64'(act_busy), 64'(0));
        step(1'b0, 4'b0110, 4'b0000, 1'b0);
        check("burst_next_gid", 64'(act_gid), 64'(1));
        check("burst_next_wr", 64'(act_wr), 64'(1));
        seen2 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 4'b0110, 4'b0000, 1'b0);
            if (act_wr && act_gid == 2'd2) seen2 = 1'b1;
        end
        check("burst_reserve2", 64'(seen2), 64'(1));

        // last on the third beat of requester 0
        do_reset();
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        step(1'b0, 4'b0001, 4'b0001, 1'b0);
        check("last3_wr_en", 64'(act_wr), 64'(1));
        step(1'b0, 4'b0001, 4'b0000, 1'b0);
        check("last3_busy", 64'(act_busy), 64'(0));
        check("last3_idle_wr", 64'(act_wr), 64'(0));
`endif

        // random traffic with occasional reset and back-pressure
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pattern = int'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0),
                 (pattern == 0) ? N'($urandom) : N'($urandom | $urandom),
                 ($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
                 ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of `async_fifo` among `NUM_REQ` producers in the write clock domain. Each producer presents valid/ready beats. The arbiter grants one producer at a time, forwards its beats straight onto `wr_en`/`wr_data`, and stalls on `full_out`. It sits directly in front of the FIFO write port and runs on `wr_clk`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..16)
- `ID_WIDTH`, 2, width of grant index; ceil(log2(`NUM_REQ`))
- `DATA_WIDTH`, 32, beat width; equals FIFO `DATA_WIDTH`
- `MAX_BURST`, 8, max beats per grant when bursts are enabled (1..2^`CNT_WIDTH`-1)
- `CNT_WIDTH`, 4, beat counter width

Ports:
- `clk`  in  1  write-side clock (FIFO `wr_clk`); single clock domain
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  `NUM_REQ`  per-requester beat valid
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last`  in  `NUM_REQ`  marks final beat of a burst
- `req_ready`  out  `NUM_REQ`  one-hot or zero; beat accepted when valid&ready
- `fifo_full`  in  1  FIFO `full_out`
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_wr_data`  out  `DATA_WIDTH`  to FIFO `wr_data`
- `grant_id`  out  `ID_WIDTH`  index of current/last grantee
- `busy`  out  1  high while in GRANT

## Operation
- FSM has two states: IDLE and GRANT.
- IDLE: if any `req_valid` is set, pick the first set bit scanning from `last_grant+1` upward, wrapping modulo `NUM_REQ`. Then register `grant_id`, clear `beat_cnt`, and go to GRANT. If none is set, stay in IDLE.
- GRANT, with grantee g:
  - `req_ready[g]` = ~`fifo_full`; all other ready bits are 0.
  - `fifo_wr_en` = `req_valid[g]` & ~`fifo_full`.
  - `fifo_wr_data` = `req_data[g]` (combinational mux).
- An accepted beat (`fifo_wr_en`=1) increments `beat_cnt`. The release condition depends on configuration (see below). On release: `last_grant` <= g, next state is IDLE.
- While granted, a dropped `req_valid[g]` holds the grant. No beat is written and the grant is not released.
- `fifo_full` stalls the grant: ready is low, no count, and the grant is held.
- `fifo_wr_en` is never high while `fifo_full`=1. This is a hard invariant.
- Reset values:
  - state IDLE, `last_grant` = `NUM_REQ`-1 (so requester 0 wins first), `grant_id` = 0, `beat_cnt` = 0.
  - Outputs: `busy`=0, `req_ready`=0, `fifo_wr_en`=0.
- `rst`=1 combinationally forces `req_ready`=0 and `fifo_wr_en`=0 in the same cycle, even while in GRANT.
- Reset mid-burst abandons the burst. The next arbitration restarts from requester 0.

## Timing
- Arbitration latency: `req_valid` high in IDLE at cycle n gives `req_ready` at cycle n+1.
- Write path is zero-latency: an accepted beat appears as `fifo_wr_en` in the same cycle.
- One IDLE bubble cycle after every release, so peak throughput with releases is 1 beat / 2 cycles. Within a burst, throughput is 1 beat/cycle.
- `fifo_full` is the registered FIFO flag and needs no extra pipeline margin.
- `grant_id` is stable through GRANT and retains its value in IDLE.

## Configuration
- `FIFO_ARB_BURST_EN` defined: the grant is held until one of these accepted beats:
  - a beat with `req_last[g]`=1, or
  - beat number `MAX_BURST` (`beat_cnt` == `MAX_BURST`-1 on accept).

  This guarantees bounded waiting for other requesters.
- `FIFO_ARB_BURST_EN` undefined:
  - release after every accepted beat;
  - `req_last` is ignored;
  - `beat_cnt` logic is removed.

## Test plan
- Reset, then `req_valid`=4'b1111 held, no full, macro off → grants 0,1,2,3,0… in order. Exactly one `fifo_wr_en` per 2 cycles, and `fifo_wr_data` matches the grantee's data.
- Macro on, `MAX_BURST`=8: requester 2 streams 12 beats with `req_last` never set, requester 1 is valid. Expect 8 consecutive beats from 2, then 1 IDLE cycle, then a grant to 3 if valid else 0 else 1 (rotation from 2), and requester 2 is re-served later.
- Macro on: `req_last` on the 3rd beat of requester 0 → release after exactly 3 writes, `busy` falls the next cycle.
- `fifo_full`=1 for 5 cycles in mid-burst with `req_valid[g]`=1 → `fifo_wr_en`=0 and `req_ready`=0 for those 5 cycles, grant unchanged, beat count unchanged. Writes resume the cycle full drops.
- `rst` pulsed for 1 cycle during a GRANT with a valid beat → `fifo_wr_en`=0 in that cycle, then IDLE with `busy`=0. The next grant goes to the lowest valid index.
- Grantee drops `req_valid` for 3 cycles while others are valid → no writes and no grant change. The burst continues when valid returns.
